// File: rtl/tx_core_pkg.sv
// Shared types and default constants for the tx_core serial transmitter.
package tx_core_pkg;

  // Frame sequencer states; PARITY is only visited when TX_CORE_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned DEF_CLK_FREQUENCY = 100_000_000;
  localparam int unsigned DEF_BAUD_RATE     = 19_200;

  // Clock cycles per serial bit (integer division, remainder dropped).
  function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/tx_baud_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1, wraps, and flags the terminal count.
module tx_baud_timer #(
  parameter int unsigned BIT_CYCLES = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned       CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: hold at zero while cleared, wrap on the terminal count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_core.sv
// Asynchronous-serial transmitter: start bit, 8 data bits LSB first,
// optional odd parity bit, one stop bit. tx and tx_busy are registered.
// Build option: define TX_CORE_PARITY_EN to insert the parity bit
// (11-bit frame); without it the frame is 10 bits.
module tx_core
  import tx_core_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = DEF_CLK_FREQUENCY,
  parameter int unsigned BAUD_RATE     = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_data,
  input  logic [7:0] data_tx,
  output logic       tx,
  output logic       tx_busy
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQUENCY, BAUD_RATE);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] idx_q, idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       tick;

  // The timer is held at zero in IDLE so every frame starts on a fresh bit period.
  tx_baud_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  assign tx      = tx_q;
  assign tx_busy = busy_q;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so the line level changes exactly on each bit boundary.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (send_data) begin
          shreg_d = data_tx;
          idx_d   = 3'd0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
`ifdef TX_CORE_PARITY_EN
            state_d = PARITY;
            tx_d    = ~(^shreg_q);
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns the line to idle mid-frame too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= 8'h00;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_tx_core.sv
// Self-checking bench for tx_core using a short bit period (8 clocks per bit).
// Frame expectations come from a bit-list model built from the frame format.
module tb_tx_core;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned BAUD   = 12_500_000;
  localparam int          B      = CLK_HZ / BAUD;
`ifdef TX_CORE_PARITY_EN
  localparam int          NBITS  = 11;
`else
  localparam int          NBITS  = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       send_data;
  logic [7:0] data_tx;
  logic       tx;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;
  logic cap [0:10];

  tx_core #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .send_data(send_data),
    .data_tx  (data_tx),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (failures=%0d)", failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%b required=%b", name, $time, act, req);
    end
  endtask

  // Called at a negedge just before the edge that samples send_data=1.
  // Checks every bit boundary of the frame, then the idle cycle after it.
  task automatic check_frame(input logic [7:0] d, input bit hold, input bit perturb);
    logic exp [0:10];
    exp[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp[i+1] = d[i];
    exp[9]  = 1'b1;
    exp[10] = 1'b1;
`ifdef TX_CORE_PARITY_EN
    exp[9] = ((d[0]+d[1]+d[2]+d[3]+d[4]+d[5]+d[6]+d[7]) % 2 == 0) ? 1'b1 : 1'b0;
`endif
    for (int c = 0; c < NBITS * B; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) send_data = 1'b0;
      if (perturb && (c == 3 * B || c == 6 * B)) data_tx = ~data_tx;
      if ((c % B == 0) || (c % B == B - 1)) begin
        chk("frame_tx", tx, exp[c / B]);
        chk("frame_busy", tx_busy, 1'b1);
      end
      if (c % B == B / 2) cap[c / B] = tx;
    end
    @(negedge clk);
    chk("idle_gap_busy", tx_busy, 1'b0);
    chk("idle_gap_tx", tx, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       parity;
    bit         perturb;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1};

    rst = 1'b1;
    send_data = 1'b0;
    data_tx = 8'h00;

    // Reset state and idle after release.
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", tx_busy, 1'b0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_tx", tx, 1'b1);
      chk("idle_busy", tx_busy, 1'b0);
    end

    // Table-driven single frames, some with data_tx changed mid-frame.
    for (int v = 0; v < 5; v++) begin
      data_tx = vecs[v].data;
      send_data = 1'b1;
      check_frame(vecs[v].data, 1'b0, vecs[v].perturb);
`ifdef TX_CORE_PARITY_EN
      chk("parity_bit", cap[9], vecs[v].parity);
      chk("stop_bit", cap[10], 1'b1);
`else
      chk("stop_after_d7", cap[9], 1'b1);
`endif
      repeat (2) @(negedge clk);
      chk("no_restart_busy", tx_busy, 1'b0);
    end

    // Back-to-back frames with send_data held high and a new byte each time.
    d = 8'($urandom);
    data_tx = d;
    send_data = 1'b1;
    for (int f = 0; f < 50; f++) begin
      check_frame(d, 1'b1, 1'b0);
      d = 8'($urandom);
      data_tx = d;
    end
    send_data = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("after_burst_busy", tx_busy, 1'b0);
    end

    // Reset in the middle of the data bits.
    data_tx = 8'h96;
    send_data = 1'b1;
    @(negedge clk);
    send_data = 1'b0;
    repeat (2 * B + 3) @(negedge clk);
    chk("mid_data_busy_before_rst", tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);

    // send_data high during reset must not start a frame until rst drops.
    send_data = 1'b1;
    data_tx = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_tx", tx, 1'b1);
      chk("rst_hold_busy", tx_busy, 1'b0);
    end
    rst = 1'b0;
    check_frame(8'h5A, 1'b0, 1'b0);

    // A few random single frames with mid-frame data changes.
    for (int f = 0; f < 4; f++) begin
      d = 8'($urandom);
      data_tx = d;
      send_data = 1'b1;
      check_frame(d, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
